// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg -- shared types and constants for the PC sequencer.
//   state_t         : sequencer FSM states (BOOT, FETCH, EXEC)
//   MCAUSE_*        : 2-bit trap cause encodings
//   DEFAULT_*_VEC   : default reset and trap entry addresses
//   is_misaligned() : true when an instruction address is not word aligned
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [1:0] MCAUSE_NONE     = 2'd0;
  localparam logic [1:0] MCAUSE_TRAP     = 2'd1;
  localparam logic [1:0] MCAUSE_MISALIGN = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- instruction fetch handshake.
//   req   : fetch request, held until ready
//   addr  : fetch address (the current PC)
//   ready : memory accepts the request and returns the word this cycle
// master = sequencer side, slave = instruction memory side.
interface pc_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;

  modport master (output req, output addr, input ready);
  modport slave  (input req, input addr, output ready);
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel -- combinational next-PC selection for the execute stage.
//   Inputs : pc, mepc, redirect requests (trap_req, mret, jump, branch_taken)
//            and their targets (jmp_target, br_target)
//   Outputs: next_pc   - PC to load when the instruction retires
//            take_trap - the selected outcome is a trap entry
//            cause     - trap cause to record when take_trap is set
// Priority: trap_req > mret > jump > branch_taken > pc + 4.
module pc_next_sel
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic [31:0] pc,
  input  logic [31:0] mepc,
  input  logic        trap_req,
  input  logic        mret,
  input  logic        jump,
  input  logic [31:0] jmp_target,
  input  logic        branch_taken,
  input  logic [31:0] br_target,
  output logic [31:0] next_pc,
  output logic        take_trap,
  output logic [1:0]  cause
);

  always_comb begin
    // Sequential fall-through; 32-bit add wraps naturally past 0xFFFF_FFFC.
    next_pc   = pc + 32'd4;
    take_trap = 1'b0;
    cause     = MCAUSE_NONE;
    if (trap_req) begin
      next_pc   = TRAP_VEC;
      take_trap = 1'b1;
      cause     = MCAUSE_TRAP;
    end else if (mret) begin
      next_pc = mepc;
    end else if (jump) begin
      // A misaligned target is never loaded; it turns into a trap instead.
      if (is_misaligned(jmp_target)) begin
        next_pc   = TRAP_VEC;
        take_trap = 1'b1;
        cause     = MCAUSE_MISALIGN;
      end else begin
        next_pc = jmp_target;
      end
    end else if (branch_taken) begin
      if (is_misaligned(br_target)) begin
        next_pc   = TRAP_VEC;
        take_trap = 1'b1;
        cause     = MCAUSE_MISALIGN;
      end else begin
        next_pc = br_target;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter sequencer with fetch handshake and traps.
//   clk, rst        : clock, asynchronous active-high reset
//   imem            : fetch handshake (req/addr out, ready in)
//   instr_valid     : fetched instruction is executing and retires this cycle
//   stall           : hold the current instruction in execute
//   branch_taken/br_target, jump/jmp_target, trap_req, mret : redirects
//   pc_out, mepc    : current PC and saved trap PC
//   trap_taken      : trap entry this cycle; mcause holds the last cause
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = DEFAULT_TRAP_VEC
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_if.master        imem,
  output logic                  instr_valid,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [31:0]           br_target,
  input  logic                  jump,
  input  logic [31:0]           jmp_target,
  input  logic                  trap_req,
  input  logic                  mret,
  output logic [31:0]           pc_out,
  output logic [31:0]           mepc,
  output logic                  trap_taken,
  output logic [1:0]            mcause
);

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] mepc_reg;
  logic [1:0]  mcause_reg;

  logic [31:0] sel_next_pc;
  logic        sel_take_trap;
  logic [1:0]  sel_cause;
  logic        exec_commit;
  logic        fetch_req;

  pc_next_sel #(
    .TRAP_VEC (TRAP_VEC)
  ) u_next_sel (
    .pc           (pc_reg),
    .mepc         (mepc_reg),
    .trap_req     (trap_req),
    .mret         (mret),
    .jump         (jump),
    .jmp_target   (jmp_target),
    .branch_taken (branch_taken),
    .br_target    (br_target),
    .next_pc      (sel_next_pc),
    .take_trap    (sel_take_trap),
    .cause        (sel_cause)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = FETCH;
      FETCH:   if (imem.ready) state_next = EXEC;
      EXEC:    if (!stall) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  // FSM outputs. Redirects only matter on the retiring EXEC cycle, so every
  // other state (and a stalled EXEC) ignores them by construction.
  always_comb begin
    fetch_req   = 1'b0;
    exec_commit = 1'b0;
    trap_taken  = 1'b0;
    case (state_reg)
      FETCH: fetch_req = 1'b1;
      EXEC: begin
        exec_commit = !stall;
        trap_taken  = !stall && sel_take_trap;
      end
      default: ;
    endcase
  end

  // PC / trap CSR registers: updated only when an instruction retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= RESET_VEC;
      mepc_reg   <= 32'h0000_0000;
      mcause_reg <= MCAUSE_NONE;
    end else if (exec_commit) begin
      pc_reg <= sel_next_pc;
      if (sel_take_trap) begin
        mepc_reg   <= pc_reg;
        mcause_reg <= sel_cause;
      end
    end
  end

  assign imem.req    = fetch_req;
  assign imem.addr   = pc_reg;
  assign instr_valid = exec_commit;
  assign pc_out      = pc_reg;
  assign mepc        = mepc_reg;
  assign mcause      = mcause_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- scoreboard bench for pc_sequencer.
// Expected fetch addresses are queued as each instruction is launched and
// compared by a monitor whenever the DUT's fetch handshake completes.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_ready;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jmp_target;
  logic        trap_req;
  logic        mret;
  logic [31:0] pc_out;
  logic [31:0] mepc;
  logic        trap_taken;
  logic [1:0]  mcause;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  pc_sequencer_if bus ();
  assign bus.ready = imem_ready;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .branch_taken (branch_taken),
    .br_target    (br_target),
    .jump         (jump),
    .jmp_target   (jmp_target),
    .trap_req     (trap_req),
    .mret         (mret),
    .pc_out       (pc_out),
    .mepc         (mepc),
    .trap_taken   (trap_taken),
    .mcause       (mcause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted fetch must match the next queued address.
  always @(negedge clk) begin
    if (bus.req && imem_ready && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected: got addr=%h required no fetch", bus.addr);
      end else begin
        logic [31:0] exp_addr;
        exp_addr = exp_q.pop_front();
        if (bus.addr !== exp_addr) begin
          errors++;
          $display("FAIL fetch_addr: got %h required %h", bus.addr, exp_addr);
        end else begin
          $display("fetch addr=%h", bus.addr);
        end
      end
    end
  end

  task automatic clear_redirects();
    stall        = 1'b0;
    branch_taken = 1'b0;
    br_target    = 32'h0;
    jump         = 1'b0;
    jmp_target   = 32'h0;
    trap_req     = 1'b0;
    mret         = 1'b0;
  endtask

  // Launch one fetch from FETCH (called at posedge+1); returns in EXEC.
  task automatic do_instr(input logic [31:0] addr);
    exp_q.push_back(addr);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
  endtask

  // Let the EXEC cycle retire and drop all redirect inputs.
  task automatic finish_exec();
    @(posedge clk); #1;
    clear_redirects();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    clear_redirects();
    @(negedge clk);
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required %h", pc_out, 32'h0); end
    checks++; if (mepc !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h required %h", mepc, 32'h0); end
    checks++; if (mcause !== 2'd0) begin errors++; $display("FAIL reset_mcause: got %0d required 0", mcause); end
    checks++; if ({bus.req, instr_valid, trap_taken} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: got req/iv/trap=%b required 000", {bus.req, instr_valid, trap_taken});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [4:0] exp_iv  = 5'b10100;
    logic [4:0] exp_req = 5'b01010;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== exp_iv[i]) begin errors++; $display("FAIL seq_instr_valid[%0d]: got %b required %b", i, instr_valid, exp_iv[i]); end
      checks++; if (bus.req !== exp_req[i]) begin errors++; $display("FAIL seq_imem_req[%0d]: got %b required %b", i, bus.req, exp_req[i]); end
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_fetch_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b required 1", i, bus.req); end
      checks++; if (bus.addr !== 32'h8) begin errors++; $display("FAIL wait_addr[%0d]: got %h required %h", i, bus.addr, 32'h8); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_iv[%0d]: got %b required 0", i, instr_valid); end
      @(posedge clk); #1;
    end
    do_instr(32'h8);
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wait_exec_iv: got %b required 1", instr_valid); end
    finish_exec();
  endtask

  task automatic test_jump_priority();
    do_instr(32'hC);
    finish_exec();
    do_instr(32'h10);
    jump = 1'b1; jmp_target = 32'h40;
    branch_taken = 1'b1; br_target = 32'h80;
    @(negedge clk);
    checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL jump_trap: got %b required 0", trap_taken); end
    finish_exec();
    @(negedge clk);
    checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL jump_pc: got %h required %h", pc_out, 32'h40); end
    @(posedge clk); #1;
    do_instr(32'h40);
    jump = 1'b1; jmp_target = 32'h20;
    finish_exec();
  endtask

  task automatic test_misaligned();
    do_instr(32'h20);
    branch_taken = 1'b1; br_target = 32'h22;
    @(negedge clk);
    checks++; if (trap_taken !== 1'b1) begin errors++; $display("FAIL mis_trap_taken: got %b required 1", trap_taken); end
    finish_exec();
    @(negedge clk);
    checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL mis_trap_pulse: got %b required 0", trap_taken); end
    checks++; if (mcause !== 2'd2) begin errors++; $display("FAIL mis_mcause: got %0d required 2", mcause); end
    checks++; if (mepc !== 32'h20) begin errors++; $display("FAIL mis_mepc: got %h required %h", mepc, 32'h20); end
    @(posedge clk); #1;
    do_instr(32'h100);
    mret = 1'b1;
    @(negedge clk);
    checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL mret_trap: got %b required 0", trap_taken); end
    finish_exec();
    @(negedge clk);
    checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL mret_pc: got %h required %h", pc_out, 32'h20); end
    checks++; if (mcause !== 2'd2) begin errors++; $display("FAIL mret_mcause_hold: got %0d required 2", mcause); end
    @(posedge clk); #1;
    do_instr(32'h20);
    jump = 1'b1; jmp_target = 32'h30;
    finish_exec();
  endtask

  task automatic test_stall();
    do_instr(32'h30);
    stall = 1'b1; trap_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL stall_trap[%0d]: got %b required 0", i, trap_taken); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_iv[%0d]: got %b required 0", i, instr_valid); end
      checks++; if (pc_out !== 32'h30) begin errors++; $display("FAIL stall_pc[%0d]: got %h required %h", i, pc_out, 32'h30); end
      checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b required 0", i, bus.req); end
      @(posedge clk); #1;
    end
    stall = 1'b0; trap_req = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_release_iv: got %b required 1", instr_valid); end
    finish_exec();
    @(negedge clk);
    checks++; if (pc_out !== 32'h34) begin errors++; $display("FAIL stall_next_pc: got %h required %h", pc_out, 32'h34); end
    @(posedge clk); #1;
  endtask

  task automatic test_trap_over_mret_and_wrap();
    do_instr(32'h34);
    trap_req = 1'b1; mret = 1'b1;
    @(negedge clk);
    checks++; if (trap_taken !== 1'b1) begin errors++; $display("FAIL trapmret_taken: got %b required 1", trap_taken); end
    finish_exec();
    @(negedge clk);
    checks++; if (mcause !== 2'd1) begin errors++; $display("FAIL trapmret_mcause: got %0d required 1", mcause); end
    checks++; if (mepc !== 32'h34) begin errors++; $display("FAIL trapmret_mepc: got %h required %h", mepc, 32'h34); end
    @(posedge clk); #1;
    do_instr(32'h100);
    jump = 1'b1; jmp_target = 32'hFFFF_FFFC;
    finish_exec();
    do_instr(32'hFFFF_FFFC);
    finish_exec();
    @(negedge clk);
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h required %h", pc_out, 32'h0); end
    @(posedge clk); #1;
    do_instr(32'h0);
    jump = 1'b1; jmp_target = 32'h50;
    finish_exec();
  endtask

  task automatic test_redirect_in_fetch();
    jump = 1'b1; jmp_target = 32'h80; trap_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL fetch_redirect_trap[%0d]: got %b required 0", i, trap_taken); end
      @(posedge clk); #1;
    end
    clear_redirects();
    @(negedge clk);
    checks++; if (pc_out !== 32'h50) begin errors++; $display("FAIL fetch_redirect_pc: got %h required %h", pc_out, 32'h50); end
    checks++; if (mepc !== 32'h34) begin errors++; $display("FAIL fetch_redirect_mepc: got %h required %h", mepc, 32'h34); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fetch();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h required %h", pc_out, 32'h0); end
    checks++; if (mepc !== 32'h0) begin errors++; $display("FAIL midrst_mepc: got %h required %h", mepc, 32'h0); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b required 0", bus.req); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(32'h0);
    imem_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL midrst_boot_req: got %b required 0", bus.req); end
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    imem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fetch_wait();
    test_jump_priority();
    test_misaligned();
    test_stall();
    test_trap_over_mret_and_wrap();
    test_redirect_in_fetch();
    test_reset_mid_fetch();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending fetches required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_VEC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter TRAP_VEC, default 32'h0000_0100, the PC value loaded on trap entry.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction fetch request, held until accepted.
REQ-006 imem_addr  output  32  fetch address, always equal to pc_out.
REQ-007 imem_ready  input  1  instruction memory accepts and returns the word this cycle.
REQ-008 instr_valid  output  1  one-cycle pulse: the fetched instruction is in the execute stage.
REQ-009 stall  input  1  hold the current instruction in execute.
REQ-010 branch_taken  input  1  conditional branch resolved taken; target on br_target[31:0].
REQ-011 jump  input  1  JAL/JALR; target on jmp_target[31:0].
REQ-012 trap_req  input  1  synchronous exception/interrupt request from execute.
REQ-013 mret  input  1  return from trap.
REQ-014 pc_out  output  32  current PC; mepc  output  32  saved trap PC.
REQ-015 trap_taken  output  1  one-cycle pulse on trap entry; mcause  output  2  cause (0 none, 1 external trap, 2 misaligned target).

Function
REQ-016 The FSM SHALL have states BOOT, FETCH, EXEC; BOOT->FETCH unconditionally after one cycle.
REQ-017 In FETCH, imem_req SHALL be 1; on imem_ready=1 the FSM SHALL move to EXEC, else remain in FETCH with pc_out unchanged.
REQ-018 instr_valid SHALL be 1 exactly during EXEC cycles with stall=0.
REQ-019 In EXEC with stall=1 the FSM SHALL remain in EXEC, ignore all redirect inputs and hold pc_out.
REQ-020 In EXEC with stall=0 the PC SHALL update and the FSM SHALL return to FETCH, next-PC priority: trap_req > mret > jump > branch_taken > pc_out+4.
REQ-021 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-022 A selected jump/branch target with bits[1:0]!=0 SHALL be replaced by a trap with mcause=2.
REQ-023 Trap entry SHALL set mepc<=pc_out, pc<=TRAP_VEC, trap_taken=1 for that cycle, mcause=1 for trap_req.
REQ-024 mret SHALL set pc<=mepc; mepc and mcause SHALL hold their values until the next trap.
REQ-025 Simultaneous trap_req and mret SHALL take the trap; simultaneous jump and branch_taken SHALL use jmp_target.
REQ-026 Redirect inputs outside EXEC SHALL be ignored.
REQ-027 Fetch-to-execute latency SHALL be one cycle after the imem_ready cycle; the minimum per-instruction period is 2 cycles.

Reset
REQ-028 rst=1 SHALL immediately force state BOOT, pc_out=RESET_VEC, mepc=0, mcause=0, imem_req=0, instr_valid=0, trap_taken=0.
REQ-029 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the operation without a PC update; the first fetch after release SHALL be RESET_VEC.

Structure
REQ-030 A shared package SHALL hold the state enum (BOOT, FETCH, EXEC), the mcause encoding constants and the default RESET_VEC/TRAP_VEC values.
REQ-031 Next-PC priority selection and misalignment check SHALL be a combinational sub-module pc_next_sel; the PC, mepc, mcause registers and FSM SHALL reside in pc_sequencer.

Verification
REQ-032 Reset release, imem_ready=1 constantly -> imem_addr sequence 0x0, 0x4, 0x8, with an instr_valid pulse every 2 cycles.
REQ-033 imem_ready low 3 cycles in FETCH at PC 0x8 -> imem_req held, imem_addr=0x8 stable, no instr_valid until ready.
REQ-034 EXEC at 0x10 with jump=1, jmp_target=0x40 and branch_taken=1, br_target=0x80 -> next fetch 0x40.
REQ-035 EXEC at 0x20 with branch_taken=1, br_target=0x22 -> trap_taken pulse, mcause=2, mepc=0x20, next fetch 0x100; later mret -> next fetch 0x20.
REQ-036 stall=1 for 2 cycles with trap_req=1 at 0x30, then stall=0, trap_req=0 -> no trap taken, pc_out held at 0x30, next fetch 0x34.
REQ-037 rst pulsed mid-FETCH at 0x50 -> pc_out=0x0 immediately, first post-reset fetch 0x0, mepc=0.
